// File: rtl/main_control_fsm.sv
// Multicycle datapath main controller: one Moore-style FSM whose outputs decode
// from the current state, with mem_ready folded in only where memory can stall.
module main_control_fsm #(
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Held as a raw 4-bit register so the unused codes 13-15 stay reachable and decodable.
    logic [3:0] state_q;
    logic [3:0] state_nxt;
    logic       mem_rdy;

    assign mem_rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
    assign state   = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUop       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        state_nxt   = S_FETCH;

        case (state_q)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b01;
                IRWrite   = mem_rdy;
                PCWrite   = mem_rdy;
                state_nxt = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    default: begin
                        illegal_op = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                state_nxt = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                state_nxt = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA   = 1'b1;
                ALUop     = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            // RESET and the spare codes 13-15 all idle for one cycle then fetch.
            default: state_nxt = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: one instance with mem_ready honoured,
// one with it ignored; expected per-cycle output vectors are queued and popped on negedge.
module tb_main_control_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 0: USE_MEM_READY=1
    logic       rst0, mr0;
    logic [5:0] op0;
    logic       pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0, ill0;
    logic [1:0] asb0, aop0, pcs0;
    logic [3:0] st0;

    // Instance 1: USE_MEM_READY=0, mem_ready tied low
    logic       rst1;
    logic       mr1;
    logic [5:0] op1;
    logic       pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1, ill1;
    logic [1:0] asb1, aop1, pcs1;
    logic [3:0] st1;

    main_control_fsm #(.USE_MEM_READY(1)) dut0 (
        .clk(clk), .reset(rst0), .opcode(op0), .mem_ready(mr0),
        .PCWrite(pcw0), .PCWriteCond(pcwc0), .IorD(iord0), .MemRead(mrd0),
        .MemWrite(mwr0), .IRWrite(irw0), .MemtoReg(m2r0), .RegDst(rdst0),
        .RegWrite(rw0), .ALUSrcA(asa0), .ALUSrcB(asb0), .ALUop(aop0),
        .PCSource(pcs0), .illegal_op(ill0), .state(st0)
    );

    main_control_fsm #(.USE_MEM_READY(0)) dut1 (
        .clk(clk), .reset(rst1), .opcode(op1), .mem_ready(mr1),
        .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mrd1),
        .MemWrite(mwr1), .IRWrite(irw1), .MemtoReg(m2r1), .RegDst(rdst1),
        .RegWrite(rw1), .ALUSrcA(asa1), .ALUSrcB(asb1), .ALUop(aop1),
        .PCSource(pcs1), .illegal_op(ill1), .state(st1)
    );

    // {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, illegal_op}
    logic [20:0] act0, act1;
    assign act0 = {st0, pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0, asb0, aop0, pcs0, ill0};
    assign act1 = {st1, pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1, asb1, aop1, pcs1, ill1};

    function automatic logic [20:0] mk(input logic [3:0] s, input logic [9:0] b,
                                       input logic [1:0] asb, input logic [1:0] aop,
                                       input logic [1:0] pcs, input logic ill);
        return {s, b, asb, aop, pcs, ill};
    endfunction

    logic [20:0] E_RESET, E_FETCH, E_FETCHW, E_DECODE, E_DECILL, E_MEMADR, E_MEMRD, E_MEMWB;
    logic [20:0] E_MEMWR, E_EXEC, E_ALUWB, E_BRANCH, E_JUMP, E_ADDIEX, E_ADDIWB;

    initial begin
        E_RESET  = mk(4'd0,  10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b0);
        E_FETCH  = mk(4'd1,  10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0);
        E_FETCHW = mk(4'd1,  10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0);
        E_DECODE = mk(4'd2,  10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0);
        E_DECILL = mk(4'd2,  10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b1);
        E_MEMADR = mk(4'd3,  10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0);
        E_MEMRD  = mk(4'd4,  10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0);
        E_MEMWB  = mk(4'd5,  10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0);
        E_MEMWR  = mk(4'd6,  10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0);
        E_EXEC   = mk(4'd7,  10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0);
        E_ALUWB  = mk(4'd8,  10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0);
        E_BRANCH = mk(4'd9,  10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0);
        E_JUMP   = mk(4'd10, 10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0);
        E_ADDIEX = mk(4'd11, 10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0);
        E_ADDIWB = mk(4'd12, 10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0);
    end

    logic [20:0] q0[$];
    logic [20:0] q1[$];
    string       n0[$];
    string       n1[$];

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every negedge that has a queued expectation, plus the exclusivity rules.
    always @(negedge clk) begin
        if (q0.size() > 0) check(n0.pop_front(), act0, q0.pop_front());
        if (q1.size() > 0) check(n1.pop_front(), act1, q1.pop_front());
        check("excl0", {19'd0, mrd0 & mwr0, rw0 & pcw0}, 21'd0);
        check("excl1", {19'd0, mrd1 & mwr1, rw1 & pcw1}, 21'd0);
    end

    task automatic cyc0(input string name, input logic [5:0] op, input logic mr, input logic [20:0] exp);
        op0 = op;
        mr0 = mr;
        q0.push_back(exp);
        n0.push_back(name);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1(input string name, input logic [5:0] op, input logic [20:0] exp);
        op1 = op;
        q1.push_back(exp);
        n1.push_back(name);
        @(posedge clk);
        #1;
    endtask

    logic done0 = 1'b0;
    logic done1 = 1'b0;

    // Instance 0 stimulus
    initial begin
        rst0 = 1'b1; op0 = 6'h00; mr0 = 1'b1;
        @(posedge clk); #1;
        cyc0("reset_held", 6'h00, 1'b1, E_RESET);
        rst0 = 1'b0;
        cyc0("reset_rel", 6'h00, 1'b1, E_RESET);
        // lw, no wait states: 1,2,3,4,5
        cyc0("lw_fetch", 6'h23, 1'b1, E_FETCH);
        cyc0("lw_decode", 6'h23, 1'b1, E_DECODE);
        cyc0("lw_memadr", 6'h23, 1'b1, E_MEMADR);
        cyc0("lw_memrd", 6'h23, 1'b1, E_MEMRD);
        cyc0("lw_memwb", 6'h23, 1'b1, E_MEMWB);
        // R-type then beq
        cyc0("r_fetch", 6'h00, 1'b1, E_FETCH);
        cyc0("r_decode", 6'h00, 1'b1, E_DECODE);
        cyc0("r_exec", 6'h00, 1'b1, E_EXEC);
        cyc0("r_aluwb", 6'h00, 1'b1, E_ALUWB);
        cyc0("beq_fetch", 6'h04, 1'b1, E_FETCH);
        cyc0("beq_decode", 6'h04, 1'b1, E_DECODE);
        cyc0("beq_branch", 6'h04, 1'b1, E_BRANCH);
        // addi
        cyc0("addi_fetch", 6'h08, 1'b1, E_FETCH);
        cyc0("addi_decode", 6'h08, 1'b1, E_DECODE);
        cyc0("addi_ex", 6'h08, 1'b1, E_ADDIEX);
        cyc0("addi_wb", 6'h08, 1'b1, E_ADDIWB);
        // lw with one fetch stall and two read stalls
        cyc0("lww_fetch_stall", 6'h23, 1'b0, E_FETCHW);
        cyc0("lww_fetch", 6'h23, 1'b1, E_FETCH);
        cyc0("lww_decode", 6'h23, 1'b1, E_DECODE);
        cyc0("lww_memadr", 6'h23, 1'b1, E_MEMADR);
        cyc0("lww_memrd_stall1", 6'h23, 1'b0, E_MEMRD);
        cyc0("lww_memrd_stall2", 6'h23, 1'b0, E_MEMRD);
        cyc0("lww_memrd", 6'h23, 1'b1, E_MEMRD);
        cyc0("lww_memwb", 6'h23, 1'b1, E_MEMWB);
        // sw with three write stalls: MemWrite held four cycles
        cyc0("sw_fetch", 6'h2B, 1'b1, E_FETCH);
        cyc0("sw_decode", 6'h2B, 1'b1, E_DECODE);
        cyc0("sw_memadr", 6'h2B, 1'b1, E_MEMADR);
        cyc0("sw_memwr_stall1", 6'h2B, 1'b0, E_MEMWR);
        cyc0("sw_memwr_stall2", 6'h2B, 1'b0, E_MEMWR);
        cyc0("sw_memwr_stall3", 6'h2B, 1'b0, E_MEMWR);
        cyc0("sw_memwr", 6'h2B, 1'b1, E_MEMWR);
        // illegal opcode: two cycles, pulse only in DECODE
        cyc0("ill_fetch", 6'h3F, 1'b1, E_FETCH);
        cyc0("ill_decode", 6'h3F, 1'b1, E_DECILL);
        // j
        cyc0("j_fetch", 6'h02, 1'b1, E_FETCH);
        cyc0("j_decode", 6'h02, 1'b1, E_DECODE);
        cyc0("j_jump", 6'h02, 1'b1, E_JUMP);
        // sw interrupted by async reset while stalled in MEMWR
        cyc0("swr_fetch", 6'h2B, 1'b1, E_FETCH);
        cyc0("swr_decode", 6'h2B, 1'b1, E_DECODE);
        cyc0("swr_memadr", 6'h2B, 1'b1, E_MEMADR);
        cyc0("swr_memwr", 6'h2B, 1'b0, E_MEMWR);
        q0.push_back(E_RESET);
        n0.push_back("swr_reset_negedge");
        #1 rst0 = 1'b1;
        #1 check("swr_async_drop", act0, E_RESET);
        @(posedge clk); #1;
        rst0 = 1'b0;
        cyc0("swr_reset_rel", 6'h2B, 1'b0, E_RESET);
        cyc0("swr_refetch", 6'h00, 1'b1, E_FETCH);
        done0 = 1'b1;
    end

    // Instance 1 stimulus: mem_ready permanently low but ignored
    initial begin
        rst1 = 1'b1; op1 = 6'h00; mr1 = 1'b0;
        @(posedge clk); #1;
        cyc1("n_reset_held", 6'h02, E_RESET);
        rst1 = 1'b0;
        cyc1("n_reset_rel", 6'h02, E_RESET);
        cyc1("n_j_fetch", 6'h02, E_FETCH);
        cyc1("n_j_decode", 6'h02, E_DECODE);
        cyc1("n_j_jump", 6'h02, E_JUMP);
        cyc1("n_lw_fetch", 6'h23, E_FETCH);
        cyc1("n_lw_decode", 6'h23, E_DECODE);
        cyc1("n_lw_memadr", 6'h23, E_MEMADR);
        cyc1("n_lw_memrd", 6'h23, E_MEMRD);
        cyc1("n_lw_memwb", 6'h23, E_MEMWB);
        cyc1("n_sw_fetch", 6'h2B, E_FETCH);
        cyc1("n_sw_decode", 6'h2B, E_DECODE);
        cyc1("n_sw_memadr", 6'h2B, E_MEMADR);
        cyc1("n_sw_memwr", 6'h2B, E_MEMWR);
        cyc1("n_after_sw", 6'h00, E_FETCH);
        done1 = 1'b1;
    end

    initial begin
        for (int i = 0; i < 2000 && !(done0 && done1); i++) @(posedge clk);
        if (!(done0 && done1)) begin
            errors++;
            checks++;
            $display("FAIL timeout: done0=%0b done1=%0b required 1 1", done0, done1);
        end
        repeat (3) @(negedge clk);
        #1;
        check("drain_q0", 21'(q0.size()), 21'd0);
        check("drain_q1", 21'(q1.size()), 21'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
